// File: rtl/game_turn_ctrl.sv
// game_turn_ctrl: turn sequencer for the two-player column-drop game.
// Optional macro GAME_TURN_AUTO_MOVE_EN: a timeout auto-places a piece
// in the lowest free column instead of forfeiting the turn.
module game_turn_ctrl #(
   parameter int NUM_COLS = 7,
   parameter int COL_W    = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                move_valid,
   input  logic [COL_W-1:0]    move_col,
   input  logic [NUM_COLS-1:0] col_full,
   input  logic                timer_timeout,
   output logic                timer_enable,
   output logic                timer_reset,
   output logic                place_req,
   output logic [COL_W-1:0]    place_col,
   output logic                place_player,
   input  logic                place_ack,
   input  logic                win_detected,
   input  logic                board_full,
   output logic                current_player,
   output logic                auto_move,
   output logic                illegal_move,
   output logic                game_over,
   output logic [1:0]          winner
);

   typedef enum logic [2:0] {
      IDLE,
      TURN_START,
      WAIT_MOVE,
      AUTO_SCAN,
      PLACE,
      SWITCH,
      GAME_OVER
   } state_t;

   state_t state;

   // Columns past NUM_COLS read as full, so out-of-range moves are illegal
   logic [2**COL_W-1:0] full_pad;
   logic                move_ok;

   // Pad the full flags out to the whole column index space
   always_comb begin
      full_pad = '1;
      full_pad[NUM_COLS-1:0] = col_full;
   end

   assign move_ok = ~full_pad[move_col];

`ifdef GAME_TURN_AUTO_MOVE_EN
   localparam logic [COL_W:0] SCAN_END = NUM_COLS[COL_W:0];
   logic [COL_W:0] scan_idx;
`endif

   // Turn state machine with all outputs registered
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         timer_enable   <= 1'b0;
         timer_reset    <= 1'b0;
         place_req      <= 1'b0;
         place_col      <= '0;
         place_player   <= 1'b0;
         current_player <= 1'b0;
         auto_move      <= 1'b0;
         illegal_move   <= 1'b0;
         game_over      <= 1'b0;
         winner         <= 2'd0;
`ifdef GAME_TURN_AUTO_MOVE_EN
         scan_idx       <= '0;
`endif
      end else begin
         timer_reset  <= 1'b0;
         illegal_move <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state          <= TURN_START;
                  current_player <= 1'b0;
                  winner         <= 2'd0;
                  timer_reset    <= 1'b1;
               end
            end
            TURN_START: begin
               state        <= WAIT_MOVE;
               timer_enable <= 1'b1;
            end
            WAIT_MOVE: begin
               if (move_valid && move_ok) begin
                  state        <= PLACE;
                  timer_enable <= 1'b0;
                  place_req    <= 1'b1;
                  place_col    <= move_col;
                  place_player <= current_player;
                  auto_move    <= 1'b0;
               end else if (timer_timeout) begin
                  timer_enable <= 1'b0;
`ifdef GAME_TURN_AUTO_MOVE_EN
                  state        <= AUTO_SCAN;
                  scan_idx     <= '0;
`else
                  state        <= SWITCH;
`endif
               end
               if (move_valid && !move_ok)
                  illegal_move <= 1'b1;
            end
`ifdef GAME_TURN_AUTO_MOVE_EN
            AUTO_SCAN: begin
               if (scan_idx == SCAN_END) begin
                  state     <= GAME_OVER;
                  game_over <= 1'b1;
                  winner    <= 2'd3;
               end else if (!full_pad[scan_idx[COL_W-1:0]]) begin
                  state        <= PLACE;
                  place_req    <= 1'b1;
                  place_col    <= scan_idx[COL_W-1:0];
                  place_player <= current_player;
                  auto_move    <= 1'b1;
               end else begin
                  scan_idx <= scan_idx + 1'b1;
               end
            end
`endif
            PLACE: begin
               if (place_ack) begin
                  place_req <= 1'b0;
                  auto_move <= 1'b0;
                  if (win_detected) begin
                     state     <= GAME_OVER;
                     game_over <= 1'b1;
                     winner    <= current_player ? 2'd2 : 2'd1;
                  end else if (board_full) begin
                     state     <= GAME_OVER;
                     game_over <= 1'b1;
                     winner    <= 2'd3;
                  end else begin
                     state <= SWITCH;
                  end
               end
            end
            SWITCH: begin
               state          <= TURN_START;
               current_player <= ~current_player;
               timer_reset    <= 1'b1;
            end
            GAME_OVER: begin
               if (start) begin
                  state          <= TURN_START;
                  current_player <= 1'b0;
                  winner         <= 2'd0;
                  game_over      <= 1'b0;
                  timer_reset    <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_game_turn_ctrl.sv
// tb_game_turn_ctrl: directed bench for game_turn_ctrl.
// Timeout checks follow GAME_TURN_AUTO_MOVE_EN as the RTL does.
module tb_game_turn_ctrl;

   localparam int NUM_COLS = 7;
   localparam int COL_W    = 3;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                start = 1'b0;
   logic                move_valid = 1'b0;
   logic [COL_W-1:0]    move_col = '0;
   logic [NUM_COLS-1:0] col_full = '0;
   logic                timer_timeout = 1'b0;
   logic                timer_enable;
   logic                timer_reset;
   logic                place_req;
   logic [COL_W-1:0]    place_col;
   logic                place_player;
   logic                place_ack = 1'b0;
   logic                win_detected = 1'b0;
   logic                board_full = 1'b0;
   logic                current_player;
   logic                auto_move;
   logic                illegal_move;
   logic                game_over;
   logic [1:0]          winner;

   int checks = 0;
   int errors = 0;

   game_turn_ctrl #(
      .NUM_COLS(NUM_COLS),
      .COL_W(COL_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .move_valid(move_valid),
      .move_col(move_col),
      .col_full(col_full),
      .timer_timeout(timer_timeout),
      .timer_enable(timer_enable),
      .timer_reset(timer_reset),
      .place_req(place_req),
      .place_col(place_col),
      .place_player(place_player),
      .place_ack(place_ack),
      .win_detected(win_detected),
      .board_full(board_full),
      .current_player(current_player),
      .auto_move(auto_move),
      .illegal_move(illegal_move),
      .game_over(game_over),
      .winner(winner)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_en"}, timer_enable, 0);
      check({tag, "_trst"}, timer_reset, 0);
      check({tag, "_req"}, place_req, 0);
      check({tag, "_col"}, place_col, 0);
      check({tag, "_pp"}, place_player, 0);
      check({tag, "_cp"}, current_player, 0);
      check({tag, "_auto"}, auto_move, 0);
      check({tag, "_ill"}, illegal_move, 0);
      check({tag, "_go"}, game_over, 0);
      check({tag, "_win"}, winner, 0);
   endtask

   task automatic do_start();
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   task automatic pulse_move(input logic [COL_W-1:0] col);
      move_col   = col;
      move_valid = 1'b1;
      step(1);
      move_valid = 1'b0;
   endtask

   task automatic do_ack(input logic w, input logic f);
      place_ack    = 1'b1;
      win_detected = w;
      board_full   = f;
      step(1);
      place_ack    = 1'b0;
      win_detected = 1'b0;
      board_full   = 1'b0;
   endtask

   task automatic wait_game_over(input int budget);
      int n = 0;
      while (!game_over && n < budget) begin
         step(1);
         n++;
      end
      check("scan_done", game_over, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      step(2);
      check_zero("rst");
      rst = 1'b0;
      step(1);
      check("idle_en", timer_enable, 0);

      do_start();
      check("ts_trst", timer_reset, 1);
      check("ts_en", timer_enable, 0);
      step(1);
      check("wm_trst", timer_reset, 0);
      check("wm_en", timer_enable, 1);
      check("wm_cp", current_player, 0);

      do_start();
      check("wm_start_trst", timer_reset, 0);
      check("wm_start_en", timer_enable, 1);

      pulse_move(3'd7);
      check("ill7", illegal_move, 1);
      check("ill7_req", place_req, 0);
      check("ill7_en", timer_enable, 1);
      step(1);
      check("ill7_drop", illegal_move, 0);
      check("ill7_trst", timer_reset, 0);

      col_full = 7'b0000100;
      pulse_move(3'd2);
      check("ill2", illegal_move, 1);
      check("ill2_req", place_req, 0);
      step(1);
      check("ill2_drop", illegal_move, 0);
      col_full = '0;

      pulse_move(3'd3);
      check("mv3_req", place_req, 1);
      check("mv3_col", place_col, 3);
      check("mv3_pp", place_player, 0);
      check("mv3_auto", auto_move, 0);
      check("mv3_en", timer_enable, 0);
      pulse_move(3'd5);
      check("pl_ign_col", place_col, 3);
      check("pl_ign_req", place_req, 1);
      do_ack(1'b0, 1'b0);
      check("ack3_req", place_req, 0);
      step(1);
      check("sw_cp", current_player, 1);
      check("sw_trst", timer_reset, 1);
      step(1);
      check("sw_en", timer_enable, 1);

`ifdef GAME_TURN_AUTO_MOVE_EN
      col_full = 7'b0000011;
      timer_timeout = 1'b1;
      step(1);
      timer_timeout = 1'b0;
      check("to_en", timer_enable, 0);
      check("to_req0", place_req, 0);
      step(1);
      check("to_req1", place_req, 0);
      step(1);
      check("to_req2", place_req, 0);
      step(1);
      check("to_req3", place_req, 1);
      check("to_col", place_col, 2);
      check("to_auto", auto_move, 1);
      check("to_pp", place_player, 1);
      col_full = '0;
      do_ack(1'b0, 1'b0);
      check("to_ack_auto", auto_move, 0);
      check("to_ack_req", place_req, 0);
      step(1);
      check("to_cp", current_player, 0);
      step(1);
`else
      timer_timeout = 1'b1;
      step(1);
      timer_timeout = 1'b0;
      check("ff_req", place_req, 0);
      check("ff_en", timer_enable, 0);
      step(1);
      check("ff_cp", current_player, 0);
      check("ff_trst", timer_reset, 1);
      check("ff_req2", place_req, 0);
      check("ff_auto", auto_move, 0);
      step(1);
      check("ff_en2", timer_enable, 1);
`endif

      pulse_move(3'd0);
      check("mv0_req", place_req, 1);
      do_ack(1'b0, 1'b0);
      step(1);
      check("p2_cp", current_player, 1);
      step(1);

      move_col      = 3'd4;
      move_valid    = 1'b1;
      timer_timeout = 1'b1;
      step(1);
      move_valid    = 1'b0;
      timer_timeout = 1'b0;
      check("both_req", place_req, 1);
      check("both_auto", auto_move, 0);
      check("both_col", place_col, 4);
      check("both_pp", place_player, 1);
      step(2);
      check("hold_req", place_req, 1);
      check("hold_col", place_col, 4);
      do_ack(1'b1, 1'b1);
      check("win2_req", place_req, 0);
      check("win2_go", game_over, 1);
      check("win2_w", winner, 2);
      do_ack(1'b1, 1'b0);
      check("go_ack_w", winner, 2);
      check("go_ack_go", game_over, 1);

      do_start();
      check("rs_go", game_over, 0);
      check("rs_w", winner, 0);
      check("rs_cp", current_player, 0);
      check("rs_trst", timer_reset, 1);
      step(1);

      pulse_move(3'd6);
      check("mv6_col", place_col, 6);
      do_ack(1'b0, 1'b1);
      check("draw_go", game_over, 1);
      check("draw_w", winner, 3);

`ifdef GAME_TURN_AUTO_MOVE_EN
      do_start();
      step(1);
      col_full = '1;
      timer_timeout = 1'b1;
      step(1);
      timer_timeout = 1'b0;
      wait_game_over(20);
      check("scan_w", winner, 3);
      check("scan_req", place_req, 0);
      col_full = '0;
`endif

      do_start();
      step(1);
      pulse_move(3'd1);
      check("pre_rst_req", place_req, 1);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      check_zero("mid");
      step(1);
      check("post_rst_req", place_req, 0);
      check("post_rst_trst", timer_reset, 0);

      do_start();
      check("p1_trst", timer_reset, 1);
      step(1);
      pulse_move(3'd0);
      do_ack(1'b1, 1'b0);
      check("win1_go", game_over, 1);
      check("win1_w", winner, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/game_turn_ctrl.md
Name: game_turn_ctrl

Overview:
- Turn sequencer for the two-player column-drop game.
- Sits directly upstream of Turn_Timer. Drives its enable and reset_timer inputs and consumes its timeout pulse.
- Accepts column moves from the player input stage and issues placement requests to the board with a req/ack handshake.
- Tracks the current player and declares the winner or a draw.

Parameters:
- NUM_COLS, 7, number of board columns.
- COL_W, 3, column index width; must satisfy 2^COL_W >= NUM_COLS.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse; begins a new game from IDLE or GAME_OVER.
- move_valid  in  1  one-cycle pulse; move_col is valid.
- move_col  in  COL_W  requested column.
- col_full  in  NUM_COLS  per-column full flags from the board, bit i = column i.
- timer_timeout  in  1  timeout pulse from Turn_Timer.
- timer_enable  out  1  to Turn_Timer enable.
- timer_reset  out  1  to Turn_Timer reset_timer.
- place_req  out  1  placement request, held until acknowledged.
- place_col  out  COL_W  column to place in.
- place_player  out  1  0 = player 1, 1 = player 2.
- place_ack  in  1  board accepted the piece; win_detected and board_full are valid in the same cycle.
- win_detected  in  1  last piece completed a line.
- board_full  in  1  no empty cells remain after the placement.
- current_player  out  1  player whose turn it is.
- auto_move  out  1  high while place_req carries a timer-generated move.
- illegal_move  out  1  one-cycle pulse when a move is rejected.
- game_over  out  1  high in GAME_OVER.
- winner  out  2  0 = none, 1 = player 1, 2 = player 2, 3 = draw.

Behaviour:
- All outputs are registered.
- Reset values (rst sampled at a clk edge): state IDLE, every output 0.
- rst asserted mid-operation aborts immediately, including an outstanding place_req; no pending move is retained.

States and transitions:
- IDLE
  - start -> TURN_START; current_player=0, winner=0.
  - All other inputs ignored.
- TURN_START
  - timer_reset=1 for exactly one cycle, timer_enable=0.
  - Next cycle -> WAIT_MOVE.
- WAIT_MOVE
  - timer_enable=1.
  - move_valid with move_col<NUM_COLS and col_full[move_col]=0: latch place_col, auto_move=0 -> PLACE.
  - move_valid otherwise: illegal_move pulses the next cycle; remain in WAIT_MOVE; the timer is not reset.
  - timer_timeout -> AUTO_SCAN, scan index=0.
  - move_valid (legal) and timer_timeout in the same cycle: the player move wins; timeout is discarded.
- AUTO_SCAN
  - timer_enable=0.
  - Examines one column per cycle from index 0 upward.
  - First column with col_full=0: latch place_col, auto_move=1 -> PLACE.
  - Index reaches NUM_COLS with no free column -> GAME_OVER, winner=3.
  - Latency: k+1 cycles for free column k.
- PLACE
  - timer_enable=0; place_req=1, place_col and place_player stable until place_ack.
  - move_valid is ignored in this state.
  - On place_ack: place_req drops the next cycle.
    - win_detected=1 -> GAME_OVER, winner=current_player+1. Win takes priority over board_full.
    - Else board_full=1 -> GAME_OVER, winner=3.
    - Else -> SWITCH.
  - place_ack outside PLACE is ignored.
- SWITCH
  - current_player toggles -> TURN_START.
- GAME_OVER
  - game_over=1; winner holds.
  - start -> TURN_START with current_player=0, winner=0, game_over=0.
- start outside IDLE/GAME_OVER is ignored.
- Column compare is unsigned; move_col values >= NUM_COLS are illegal. No wrap-around.

Optional Feature:
- Macro: GAME_TURN_AUTO_MOVE_EN.
- Defined: timeout behaves as above (AUTO_SCAN and an automatic placement).
- Undefined:
  - Timeout forfeits the turn. WAIT_MOVE goes -> SWITCH with no placement; auto_move is tied 0.
  - AUTO_SCAN logic is absent.
  - A draw arises only from board_full.

Test Plan:
- Reset, then start:
  - One cycle later, timer_reset=1 for one cycle.
  - Then timer_enable=1, current_player=0.
- Legal move, move_col=3, col_full=0:
  - place_req=1, place_col=3, place_player=0.
  - place_ack with win=0, full=0 -> current_player=1, timer_reset pulses.
- move_col=7 with NUM_COLS=7, and move_col=2 with col_full[2]=1:
  - illegal_move pulses each time; state stays WAIT_MOVE; no place_req.
- timer_timeout with col_full=7'b0000011 (AUTO_MOVE_EN defined):
  - place_req after 3 cycles, place_col=2, auto_move=1.
- Macro undefined, timer_timeout:
  - No place_req; current_player toggles; timer_reset pulses.
- Player 2 (current_player=1) move, then place_ack with win_detected=1 and board_full=1:
  - game_over=1, winner=2.
  - start -> winner=0, current_player=0.
- rst asserted while place_req=1:
  - Next cycle all outputs 0, state IDLE.
- Legal move_valid and timer_timeout in the same cycle:
  - Player move placed; auto_move=0.
